// File: rtl/z16_pkg.sv
// Z16 shared types: opcode constants, widths and the decoded bundle.
// Imported by the decode stage and its scoreboard.
package z16_pkg;

  localparam int REG_AW  = 4;
  localparam int INSTR_W = 16;

  typedef logic [3:0] opcode_t;

  localparam opcode_t OP_ADD  = 4'h0;
  localparam opcode_t OP_SUB  = 4'h1;
  localparam opcode_t OP_AND  = 4'h2;
  localparam opcode_t OP_OR   = 4'h3;
  localparam opcode_t OP_XOR  = 4'h4;
  localparam opcode_t OP_SLL  = 4'h5;
  localparam opcode_t OP_SRL  = 4'h6;
  localparam opcode_t OP_SRA  = 4'h7;
  localparam opcode_t OP_SLT  = 4'h8;
  localparam opcode_t OP_ADDI = 4'h9;
  localparam opcode_t OP_LD   = 4'hA;
  localparam opcode_t OP_ST   = 4'hB;
  localparam opcode_t OP_LUI  = 4'hC;
  localparam opcode_t OP_JRL  = 4'hD;

  typedef struct packed {
    opcode_t              opcode;
    logic [REG_AW-1:0]    rd;
    logic [REG_AW-1:0]    rs1;
    logic [REG_AW-1:0]    rs2;
    logic [INSTR_W-1:0]   imm;
    logic                 rd_wen;
    logic                 mem_wen;
    logic [3:0]           alu_ctrl;
  } dec_t;

  function automatic logic [INSTR_W-1:0] sext4(
    input logic [3:0] v
  );
    return {{(INSTR_W-4){v[3]}}, v};
  endfunction

  function automatic logic [INSTR_W-1:0] sext8(
    input logic [7:0] v
  );
    return {{(INSTR_W-8){v[7]}}, v};
  endfunction

endpackage

// File: rtl/z16_scoreboard.sv
// Z16 pending-write scoreboard: one bit per register, set on issue,
// cleared on writeback (set wins); reports a hit on rs1/rs2/rd lookup.
module z16_scoreboard
  import z16_pkg::*;
#(
  parameter int NREG = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              set_en,
  input  logic [REG_AW-1:0] set_addr,
  input  logic              clr_en,
  input  logic [REG_AW-1:0] clr_addr,
  input  logic [REG_AW-1:0] rs1_addr,
  input  logic              rs1_use,
  input  logic [REG_AW-1:0] rs2_addr,
  input  logic              rs2_use,
  input  logic [REG_AW-1:0] rd_addr,
  input  logic              rd_use,
  output logic              hit
);

  logic [NREG-1:0] pend_q;
  logic [15:0]     pend_w;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        if (set_en && set_addr == REG_AW'(r))
          pend_q[r] <= 1'b1;
        else if (clr_en && clr_addr == REG_AW'(r))
          pend_q[r] <= 1'b0;
      end
    end
  end

  // Untracked addresses (NREG < 16) read as never pending.
  assign pend_w = 16'(pend_q);

  assign hit = (rs1_use & pend_w[rs1_addr])
             | (rs2_use & pend_w[rs2_addr])
             | (rd_use  & pend_w[rd_addr]);

endmodule

// File: rtl/z16_decode_stage.sv
// Z16 decode stage: decodes i_instr, stalls on RAW/WAW hazards, and
// holds the result in a valid/ready output register.
// Ports: fetch (i_valid/o_ready/i_instr), execute (o_valid/i_ready +
// decoded fields), i_flush, writeback (i_wb_valid/i_wb_addr).
// Z16_DEC_PERF_EN adds o_stall_cnt, a saturating hazard-stall counter.
module z16_decode_stage
  import z16_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int NREG   = 16
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [INSTR_W-1:0] i_instr,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [3:0]         o_opcode,
  output logic [REG_AW-1:0]  o_rd_addr,
  output logic [REG_AW-1:0]  o_rs1_addr,
  output logic [REG_AW-1:0]  o_rs2_addr,
  output logic [DATA_W-1:0]  o_imm,
  output logic               o_rd_wen,
  output logic               o_mem_wen,
  output logic [3:0]         o_alu_ctrl,
  input  logic               i_flush,
  input  logic               i_wb_valid,
  input  logic [REG_AW-1:0]  i_wb_addr
`ifdef Z16_DEC_PERF_EN
  ,
  output logic [15:0]        o_stall_cnt
`endif
);

  dec_t    dec;
  dec_t    out_q;
  logic    vld_q;
  opcode_t op;
  logic    rs1_use;
  logic    rs2_use;
  logic    sb_hit;
  logic    fwd_hit;
  logic    hazard;
  logic    accept;
  logic    sb_set;

  assign op = i_instr[3:0];

  always_comb begin
    dec          = '0;
    dec.opcode   = op;
    dec.rd       = i_instr[7:4];
    dec.rs2      = i_instr[15:12];
    dec.rs1      = (op == OP_ADDI) ? i_instr[7:4]
                                   : i_instr[11:8];
    dec.rd_wen   = (op <= OP_LD) | (op == OP_LUI)
                 | (op == OP_JRL);
    dec.mem_wen  = (op == OP_ST);
    dec.alu_ctrl = (op <= OP_SLT) ? op : OP_ADD;
    unique case (1'b1)
      (op == OP_ADDI):
        dec.imm = sext8(i_instr[15:8]);
      (op == OP_LD), (op == OP_LUI), (op == OP_JRL):
        dec.imm = sext4(i_instr[15:12]);
      (op == OP_ST):
        dec.imm = sext4(i_instr[7:4]);
      default:
        dec.imm = '0;
    endcase
  end

  assign rs1_use = (op <= OP_JRL);
  assign rs2_use = (op <= OP_SLT) | (op == OP_ST);

  // The instruction sitting in the output register has not yet set
  // its scoreboard bit, so it is checked separately.
  assign fwd_hit = vld_q & out_q.rd_wen & (
                     (rs1_use    & (dec.rs1 == out_q.rd))
                   | (rs2_use    & (dec.rs2 == out_q.rd))
                   | (dec.rd_wen & (dec.rd  == out_q.rd)));

  assign hazard  = sb_hit | fwd_hit;
  assign o_ready = ~i_rst & ~i_flush & ~hazard
                 & (~vld_q | i_ready);
  assign accept  = i_valid & o_ready;
  assign sb_set  = vld_q & i_ready & out_q.rd_wen & ~i_flush;

  z16_scoreboard #(
    .NREG (NREG)
  ) u_sb (
    .clk      (i_clk),
    .rst      (i_rst),
    .set_en   (sb_set),
    .set_addr (out_q.rd),
    .clr_en   (i_wb_valid),
    .clr_addr (i_wb_addr),
    .rs1_addr (dec.rs1),
    .rs1_use  (rs1_use),
    .rs2_addr (dec.rs2),
    .rs2_use  (rs2_use),
    .rd_addr  (dec.rd),
    .rd_use   (dec.rd_wen),
    .hit      (sb_hit)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      out_q <= '0;
      vld_q <= 1'b0;
    end else if (accept) begin
      out_q <= dec;
      vld_q <= 1'b1;
    end else if (i_flush | i_ready) begin
      vld_q <= 1'b0;
    end
  end

  assign o_valid    = vld_q;
  assign o_opcode   = out_q.opcode;
  assign o_rd_addr  = out_q.rd;
  assign o_rs1_addr = out_q.rs1;
  assign o_rs2_addr = out_q.rs2;
  assign o_imm      = DATA_W'($signed(out_q.imm));
  assign o_rd_wen   = out_q.rd_wen;
  assign o_mem_wen  = out_q.mem_wen;
  assign o_alu_ctrl = out_q.alu_ctrl;

`ifdef Z16_DEC_PERF_EN
  logic [15:0] stall_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)
      stall_q <= '0;
    else if (i_valid & hazard & ~i_flush
             & (stall_q != 16'hFFFF))
      stall_q <= stall_q + 16'd1;
  end

  assign o_stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_z16_decode_stage.sv
// Directed bench for z16_decode_stage (DATA_W=32): decode, backpressure,
// hazards, same-cycle set/clear, flush and async reset.
module tb_z16_decode_stage;

  logic        clk;
  logic        rst;
  logic        i_valid;
  logic        o_ready;
  logic [15:0] i_instr;
  logic        o_valid;
  logic        i_ready;
  logic [3:0]  o_opcode;
  logic [3:0]  o_rd_addr;
  logic [3:0]  o_rs1_addr;
  logic [3:0]  o_rs2_addr;
  logic [31:0] o_imm;
  logic        o_rd_wen;
  logic        o_mem_wen;
  logic [3:0]  o_alu_ctrl;
  logic        i_flush;
  logic        wb_valid;
  logic [3:0]  wb_addr;
`ifdef Z16_DEC_PERF_EN
  logic [15:0] o_stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  z16_decode_stage #(
    .DATA_W (32),
    .NREG   (16)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .i_instr    (i_instr),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_opcode   (o_opcode),
    .o_rd_addr  (o_rd_addr),
    .o_rs1_addr (o_rs1_addr),
    .o_rs2_addr (o_rs2_addr),
    .o_imm      (o_imm),
    .o_rd_wen   (o_rd_wen),
    .o_mem_wen  (o_mem_wen),
    .o_alu_ctrl (o_alu_ctrl),
    .i_flush    (i_flush),
    .i_wb_valid (wb_valid),
    .i_wb_addr  (wb_addr)
`ifdef Z16_DEC_PERF_EN
    ,
    .o_stall_cnt (o_stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1; i_valid = 0; i_instr = '0; i_ready = 0;
    i_flush = 0; wb_valid = 0; wb_addr = '0;
    #12;
    chk("rst_valid", o_valid, 0);
    chk("rst_ready", o_ready, 0);
    chk("rst_imm", o_imm, 0);
    rst = 0;
    tick;

    // addi r3, r3, 0x12
    i_ready = 1; i_valid = 1; i_instr = 16'h1239;
    #1 chk("addi_ready", o_ready, 1);
    tick;
    chk("addi_valid", o_valid, 1);
    chk("addi_op", o_opcode, 4'h9);
    chk("addi_rd", o_rd_addr, 3);
    chk("addi_rs1", o_rs1_addr, 3);
    chk("addi_imm", o_imm, 32'h12);
    chk("addi_rdwen", o_rd_wen, 1);
    chk("addi_alu", o_alu_ctrl, 0);
    chk("addi_memwen", o_mem_wen, 0);

    // ld r2, -1(r1), back-to-back
    i_instr = 16'hF12A;
    #1 chk("ld_b2b_ready", o_ready, 1);
    tick;
    chk("ld_valid", o_valid, 1);
    chk("ld_op", o_opcode, 4'hA);
    chk("ld_imm", o_imm, 32'hFFFF_FFFF);
    chk("ld_rs1", o_rs1_addr, 1);
    chk("ld_rd", o_rd_addr, 2);

    i_valid = 0; wb_valid = 1; wb_addr = 3;
    tick;
    wb_addr = 2;
    tick;
    wb_valid = 0;
    chk("drain_valid", o_valid, 0);

    // store, then backpressure
    i_ready = 0; i_valid = 1; i_instr = 16'h5A6B;
    tick;
    chk("st_op", o_opcode, 4'hB);
    chk("st_memwen", o_mem_wen, 1);
    chk("st_rdwen", o_rd_wen, 0);
    chk("st_imm", o_imm, 32'h6);
    i_instr = 16'h4327;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_ready", o_ready, 0);
      chk("bp_hold_op", o_opcode, 4'hB);
      chk("bp_hold_valid", o_valid, 1);
      tick;
    end
    i_ready = 1;
    #1 chk("bp_release", o_ready, 1);
    tick;
    chk("sra_valid", o_valid, 1);
    chk("sra_alu", o_alu_ctrl, 4'h7);
    chk("sra_rd", o_rd_addr, 2);
    chk("sra_rs2", o_rs2_addr, 4);

    // RAW on r1
    i_instr = 16'h0310;
    #1 chk("raw_issue_ready", o_ready, 1);
    tick;
    i_valid = 0; wb_valid = 1; wb_addr = 2;
    tick;
    wb_valid = 0;
    i_valid = 1; i_instr = 16'h0120;
    for (int i = 0; i < 3; i++) begin
      #1 chk("raw_stall", o_ready, 0);
      tick;
    end
    wb_valid = 1; wb_addr = 1;
    #1 chk("raw_nobypass", o_ready, 0);
    tick;
    wb_valid = 0;
    #1 chk("raw_release", o_ready, 1);
    tick;
    chk("raw_acc_valid", o_valid, 1);
    chk("raw_acc_rs1", o_rs1_addr, 1);
    chk("raw_acc_rd", o_rd_addr, 2);
`ifdef Z16_DEC_PERF_EN
    chk("perf_cnt", o_stall_cnt, 4);
`endif

    // same-cycle set/clear of r5
    i_instr = 16'h0050;
    #1 chk("r5_ready", o_ready, 1);
    tick;
    i_valid = 0; wb_valid = 1; wb_addr = 5;
    tick;
    wb_valid = 0;
    i_valid = 1; i_instr = 16'h0501;
    #1 chk("setwins_stall", o_ready, 0);
    tick;
    chk("setwins_stall2", o_ready, 0);
    i_valid = 0; wb_valid = 1; wb_addr = 5;
    tick;
    wb_addr = 2;
    tick;
    wb_valid = 0;

    // flush of rd=7
    i_valid = 1; i_instr = 16'h0072;
    #1 chk("f_issue_ready", o_ready, 1);
    tick;
    i_instr = 16'h0731; i_flush = 1;
    #1 chk("flush_block", o_ready, 0);
    tick;
    i_flush = 0;
    chk("flush_valid", o_valid, 0);
    #1 chk("flush_nobit", o_ready, 1);
    tick;
    chk("post_flush_valid", o_valid, 1);
    chk("post_flush_rs1", o_rs1_addr, 7);

    // async reset with pending bit and valid output
    i_valid = 0;
    tick;
    i_valid = 1; i_instr = 16'h0094;
    tick;
    i_ready = 0; i_instr = 16'h0030;
    #1 chk("pre_rst_ready", o_ready, 0);
    chk("pre_rst_valid", o_valid, 1);
    #1 rst = 1;
    #1;
    chk("arst_valid", o_valid, 0);
    chk("arst_ready", o_ready, 0);
    chk("arst_op", o_opcode, 0);
    chk("arst_rd", o_rd_addr, 0);
    chk("arst_rdwen", o_rd_wen, 0);
`ifdef Z16_DEC_PERF_EN
    chk("arst_perf", o_stall_cnt, 0);
`endif
    rst = 0;
    #1 chk("arst_sb_clear", o_ready, 1);
    tick;
    chk("post_rst_valid", o_valid, 1);
    chk("post_rst_rd", o_rd_addr, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/z16_decode_stage.md
Name: z16_decode_stage

Overview:
- Registered, flow-controlled decode stage for the Z16 pipeline. It sits between fetch and execute.
- Decodes one 16-bit instruction per cycle into opcode, register addresses, sign-extended immediate and control bits.
- Holds the result in an output register with a valid/ready handshake.
- Stalls on RAW/WAW hazards using an internal per-register pending-write scoreboard that the writeback port clears.

Parameters:
- DATA_W, 16, immediate output width; legal values ≥16; sign extension fills all upper bits.
- NREG, 16, number of architectural registers tracked; register addresses are 4 bits, so NREG ≤16.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  asynchronous active-high reset
- i_valid  in  1  fetch offers i_instr
- o_ready  out  1  stage accepts i_instr this cycle
- i_instr  in  16  instruction word
- o_valid  out  1  decoded output register holds an instruction
- i_ready  in  1  execute consumes the output this cycle
- o_opcode  out  4  instr[3:0]
- o_rd_addr  out  4  instr[7:4]
- o_rs1_addr  out  4  instr[7:4] for opcode 9, else instr[11:8]
- o_rs2_addr  out  4  instr[15:12]
- o_imm  out  DATA_W  sign-extended immediate
- o_rd_wen  out  1  destination write enable
- o_mem_wen  out  1  memory write enable
- o_alu_ctrl  out  4  ALU operation
- i_flush  in  1  kill the instruction in the output register and block acceptance this cycle
- i_wb_valid  in  1  writeback retires a register write
- i_wb_addr  in  4  register being written back

Behaviour:
- Reset (async, i_rst=1): o_valid=0, all decoded outputs 0, scoreboard all clear. o_ready is 0 while i_rst is asserted.
- Decode map:
  - imm: op9 → instr[15:8]; opA, opC, opD → instr[15:12]; opB → instr[7:4]; others → 0. All sign-extended to DATA_W.
  - rd_wen: 1 for op ≤ A, opC and opD; else 0.
  - mem_wen: 1 only for opB.
  - alu_ctrl: op for op ≤ 8, else 0 (ADD).
- Source usage:
  - rs1 is used by opcodes 0–D.
  - rs2 is used by opcodes 0–8 and B.
  - opE and opF use no sources.
- Hazard, combinational, evaluated on i_instr: a used source, or rd when rd_wen=1, matches either
  - a set scoreboard bit, or
  - the output register's rd when o_valid & o_rd_wen.
- o_ready = ~i_flush & ~hazard & (~o_valid | i_ready).
- Accept (i_valid & o_ready): the output register loads the decoded fields and o_valid=1 next cycle. Latency is exactly 1 cycle.
- Drain: when o_valid & i_ready and no new accept, o_valid=0 next cycle. Fields hold their last value when not valid.
- Outputs are stable while o_valid & ~i_ready (no change until consumed).
- Scoreboard:
  - Set bit[o_rd_addr] when o_valid & i_ready & o_rd_wen & ~i_flush.
  - Clear bit[i_wb_addr] when i_wb_valid.
  - Set and clear of the same register in the same cycle: set wins.
  - i_wb_valid for a non-pending register has no effect.
  - A writeback does not bypass the hazard check. The stall releases the cycle after the clear.
- Flush: o_valid=0 next cycle and the flushed instruction sets no scoreboard bit. The scoreboard itself is retained.
- Simultaneous drain and accept: the output register is replaced back-to-back with no bubble.

Optional Feature:
- Macro Z16_DEC_PERF_EN.
- Enabled: adds output o_stall_cnt (16 bits), which counts cycles with i_valid & hazard & ~i_flush. It saturates at 0xFFFF and resets to 0.
- Disabled: the port and counter are absent, and behaviour is otherwise identical.

Decomposition:
- Package z16_pkg holds:
  - opcode constants OP_ADD..OP_JRL (0x0–0xD);
  - REG_AW=4 and INSTR_W=16;
  - a decoded-instruction struct typedef (opcode, rd, rs1, rs2, imm, rd_wen, mem_wen, alu_ctrl).
- Sub-module z16_scoreboard holds the NREG pending bits, set/clear logic and two-source-plus-rd lookup. The decode itself stays combinational inside the stage.

Test Plan:
- Decode sweep: accept 0x1239 (addi) with i_ready=1 → next cycle o_valid=1, o_rs1_addr=3, o_imm=0x0012, o_rd_wen=1, o_alu_ctrl=0. 0xF12A with DATA_W=32 → o_imm=0xFFFFFFFF.
- Backpressure: i_ready=0 for 5 cycles with i_valid=1 → o_ready=0, outputs unchanged. Raise i_ready → back-to-back accept with no bubble.
- RAW hazard: issue 0x0310 (op0, rd=1), drain it, offer 0x0120 (rs1=1) → o_ready=0 until i_wb_valid, i_wb_addr=1. o_ready=1 the cycle after the clear.
- Same-cycle set/clear: drain rd=5 while i_wb_valid, wb_addr=5 → bit 5 remains set. A subsequent op reading r5 stalls.
- Flush: o_valid=1 with rd=7, i_flush=1, i_ready=1 → o_valid=0 next cycle, bit 7 clear. An op reading r7 is accepted immediately after.
- Reset mid-stall: scoreboard bits set and o_valid=1, pulse i_rst asynchronously → o_valid=0 and all bits clear without a clock edge. With Z16_DEC_PERF_EN, o_stall_cnt=0.
